// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem handshake, IF/ID presentation.
// Optional performance counters are enabled with `define IF_STAGE_PERF_EN.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        F_valid,
  output logic [31:0] F_PC,
  output logic [31:0] F_instruction
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait
`endif
);

  state_t      state_q;
  logic        active_q;
  logic [31:0] pc_q;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic [31:0] pend_pc;
  logic [31:0] redir_addr;

  assign redir_addr = redirect_pc & ~32'h3;

  // active_q keeps imem_req low until the first edge after reset release
  always_comb begin
    imem_req  = active_q && (state_q != HOLD);
    imem_addr = pc_q;
    case (state_q)
      FETCH:   F_valid = active_q && imem_ack && !redirect_valid;
      HOLD:    F_valid = !redirect_valid;
      default: F_valid = 1'b0;
    endcase
    if (F_valid) begin
      F_PC          = (state_q == HOLD) ? buf_pc : pc_q;
      F_instruction = (state_q == HOLD) ? buf_instr : imem_rdata;
    end else begin
      F_PC          = 32'h0000_0000;
      F_instruction = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      active_q  <= 1'b0;
      pc_q      <= RESET_PC;
      buf_pc    <= 32'h0000_0000;
      buf_instr <= 32'h0000_0000;
      pend_pc   <= 32'h0000_0000;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            // An unanswered request cannot be withdrawn, so its answer must be dropped
            if (imem_req && !imem_ack) begin
              pend_pc <= redir_addr;
              state_q <= DROP;
            end else begin
              pc_q <= redir_addr;
            end
          end else if (imem_req && imem_ack) begin
            if (stall) begin
              buf_pc    <= pc_q;
              buf_instr <= imem_rdata;
              state_q   <= HOLD;
            end else begin
              pc_q <= pc_q + PC_STEP;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redir_addr;
            state_q <= FETCH;
          end else if (!stall) begin
            pc_q    <= buf_pc + PC_STEP;
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (redirect_valid) begin
            pend_pc <= redir_addr;
          end
          if (imem_ack) begin
            pc_q    <= redirect_valid ? redir_addr : pend_pc;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef IF_STAGE_PERF_EN
  // Both counters saturate rather than wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_wait    <= 32'h0000_0000;
    end else begin
      if (F_valid && !stall && !redirect_valid && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (imem_req && !imem_ack && (perf_wait != 32'hFFFF_FFFF)) begin
        perf_wait <= perf_wait + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage with hand-written reset sequences.
module tb_if_stage;
  import if_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        F_valid;
  logic [31:0] F_PC;
  logic [31:0] F_instruction;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_wait;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[22];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .F_valid(F_valid),
    .F_PC(F_PC),
    .F_instruction(F_instruction)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_wait(perf_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic a, input logic [31:0] rd, input logic ereq,
                              input logic [31:0] eaddr, input logic ev,
                              input logic [31:0] epc, input logic [31:0] ei);
    vec_t v;
    v.stall = s; v.redir = r; v.redir_pc = rpc; v.ack = a; v.rdata = rd;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ei;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic r, input logic [31:0] rpc,
                                input logic a, input logic [31:0] rd);
    stall = s; redirect_valid = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
  endtask

  initial begin
    // Zero-wait stream, stall/HOLD, redirect during wait, HOLD redirect, DROP chain, PC wrap
    vecs[0]  = mk(0, 0, 0,            1, 32'h1111_0000, 1, 32'h0,   1, 32'h0,   32'h1111_0000);
    vecs[1]  = mk(0, 0, 0,            1, 32'h2222_0004, 1, 32'h4,   1, 32'h4,   32'h2222_0004);
    vecs[2]  = mk(0, 0, 0,            1, 32'h3333_0008, 1, 32'h8,   1, 32'h8,   32'h3333_0008);
    vecs[3]  = mk(0, 0, 0,            1, 32'h4444_000C, 1, 32'hC,   1, 32'hC,   32'h4444_000C);
    vecs[4]  = mk(1, 0, 0,            1, 32'hDEAD_0010, 1, 32'h10,  1, 32'h10,  32'hDEAD_0010);
    vecs[5]  = mk(1, 0, 0,            0, 32'h1234_5678, 0, 32'h0,   1, 32'h10,  32'hDEAD_0010);
    vecs[6]  = mk(1, 0, 0,            0, 32'h1234_5678, 0, 32'h0,   1, 32'h10,  32'hDEAD_0010);
    vecs[7]  = mk(0, 0, 0,            0, 32'h1234_5678, 0, 32'h0,   1, 32'h10,  32'hDEAD_0010);
    vecs[8]  = mk(0, 1, 32'h200,      0, 32'h0,         1, 32'h14,  0, 32'h0,   NOP_INSTR);
    vecs[9]  = mk(0, 0, 0,            0, 32'h0,         1, 32'h14,  0, 32'h0,   NOP_INSTR);
    vecs[10] = mk(0, 0, 0,            1, 32'h0BAD_0014, 1, 32'h14,  0, 32'h0,   NOP_INSTR);
    vecs[11] = mk(0, 0, 0,            1, 32'h5555_0200, 1, 32'h200, 1, 32'h200, 32'h5555_0200);
    vecs[12] = mk(1, 0, 0,            1, 32'h0BEE_F204, 1, 32'h204, 1, 32'h204, 32'h0BEE_F204);
    vecs[13] = mk(1, 1, 32'h103,      0, 32'h0,         0, 32'h0,   0, 32'h0,   NOP_INSTR);
    vecs[14] = mk(0, 0, 0,            1, 32'h6666_0100, 1, 32'h100, 1, 32'h100, 32'h6666_0100);
    vecs[15] = mk(0, 1, 32'h300,      0, 32'h0,         1, 32'h104, 0, 32'h0,   NOP_INSTR);
    vecs[16] = mk(1, 1, 32'h400,      0, 32'h0,         1, 32'h104, 0, 32'h0,   NOP_INSTR);
    vecs[17] = mk(0, 1, 32'h500,      1, 32'h0BAD_0104, 1, 32'h104, 0, 32'h0,   NOP_INSTR);
    vecs[18] = mk(0, 1, 32'hFFFF_FFFC,1, 32'h7777_0500, 1, 32'h500, 0, 32'h0,   NOP_INSTR);
    vecs[19] = mk(0, 0, 0,            1, 32'h8888_FFFC, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h8888_FFFC);
    vecs[20] = mk(0, 0, 0,            1, 32'h9999_0000, 1, 32'h0,   1, 32'h0,   32'h9999_0000);
    vecs[21] = mk(0, 0, 0,            0, 32'h0,         1, 32'h4,   0, 32'h0,   NOP_INSTR);

    rst = 1'b0;
    apply_stimulus(0, 0, 0, 1, 32'hABCD_EF01);
    repeat (2) @(negedge clk);
    #1;
    check_output("reset_req",   {31'd0, imem_req}, 32'd0);
    check_output("reset_valid", {31'd0, F_valid},  32'd0);
    check_output("reset_pc",    F_PC,              32'h0);
    check_output("reset_instr", F_instruction,     NOP_INSTR);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].stall, vecs[i].redir, vecs[i].redir_pc, vecs[i].ack, vecs[i].rdata);
      #1;
      check_output($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) check_output($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      check_output($sformatf("v%0d_valid", i), {31'd0, F_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check_output($sformatf("v%0d_pc", i), F_PC, vecs[i].exp_pc);
      check_output($sformatf("v%0d_instr", i), F_instruction, vecs[i].exp_instr);
    end

    // Reset in the middle of an outstanding request takes effect without a clock edge
    @(negedge clk);
    apply_stimulus(0, 0, 0, 1, 32'hCAFE_0004);
    rst = 1'b0;
    #1;
    check_output("midreset_req",   {31'd0, imem_req}, 32'd0);
    check_output("midreset_valid", {31'd0, F_valid},  32'd0);
    check_output("midreset_instr", F_instruction,     NOP_INSTR);

    @(negedge clk);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_output("restart_req",  {31'd0, imem_req}, 32'd1);
    check_output("restart_addr", imem_addr,          32'h0);
    apply_stimulus(0, 0, 0, 1, 32'h0000_0093);
    #1;
    check_output("restart_valid", {31'd0, F_valid}, 32'd1);
    check_output("restart_pc",    F_PC,              32'h0);
    check_output("restart_instr", F_instruction,     32'h0000_0093);
    @(negedge clk);
    apply_stimulus(0, 0, 0, 0, 32'h0);
    #1;
    check_output("restart_next_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives a single-outstanding-request instruction-memory handshake.
- Presents fetched PC/instruction pairs to the IF/ID pipeline register with a valid flag.
- Holds a fetched instruction across pipeline stalls.
- Accepts PC redirects from the branch/jump resolution logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- stall  input  1  downstream cannot accept this cycle (IF/ID register holding)
- redirect_valid  input  1  replace fetch stream with redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  output  1  instruction memory request
- imem_addr  output  32  request address; stable while imem_req high and no ack
- imem_ack  input  1  response valid; completes the current request
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- F_valid  output  1  F_PC/F_instruction carry a real instruction
- F_PC  output  32  PC of presented instruction
- F_instruction  output  32  presented instruction; NOP (32'h0000_0013) when F_valid=0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, asynchronous):
  - pc_q=RESET_PC, state=FETCH, buffers cleared.
  - Outputs: imem_req=0, F_valid=0, F_PC=0, F_instruction=NOP.
  - imem_req rises in the first cycle after reset release.
- Request rules:
  - Once imem_req is asserted, it and imem_addr are held unchanged until imem_ack.
  - A request is never withdrawn.
  - One request outstanding at most.
  - imem_ack may arrive in the request cycle (zero wait) or later.
- State FETCH:
  - imem_req=1, imem_addr=pc_q.
  - ack, no redirect: F_valid=1, F_PC=pc_q, F_instruction=imem_rdata (combinational bypass, same cycle).
    - If !stall: pc_q<=pc_q+4, stay FETCH. Sustains 1 instruction/cycle with zero-wait memory.
    - If stall: capture pc_q/imem_rdata into hold buffer; go HOLD.
  - No ack, no redirect: F_valid=0, stay FETCH.
  - Redirect with ack: discard data, F_valid=0, pc_q<=redirect_pc, stay FETCH.
  - Redirect without ack: pend_pc<=redirect_pc, go DROP.
- State HOLD:
  - imem_req=0; F_valid=1, F_PC/F_instruction from hold buffer.
  - Redirect: discard buffer, pc_q<=redirect_pc, go FETCH.
  - Else !stall: instruction consumed this cycle, pc_q<=buf_pc+4, go FETCH.
  - Else stay HOLD; outputs stable.
- State DROP:
  - imem_req=1 with the old address; F_valid=0.
  - Further redirect: pend_pc<=redirect_pc (latest wins).
  - On ack: data discarded, pc_q<=pend_pc (or redirect_pc if a redirect arrives in the ack cycle), go FETCH.
- Priority: rst > redirect_valid > stall.
- Arithmetic: PC increments are 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Invalid outputs:
  - F_PC is don't-care when F_valid=0.
  - F_instruction is forced to NOP when F_valid=0.
  - A downstream register can therefore latch either output unconditionally.
- Reset mid-request: the request is abandoned. Memory must tolerate this; it is reset by the same rst.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_wait[31:0], both saturating at 32'hFFFF_FFFF, both cleared by rst.
  - perf_fetched increments on each consumed instruction (F_valid & !stall & !redirect_valid).
  - perf_wait increments each cycle imem_req=1 & imem_ack=0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg holds:
  - state enum {FETCH, HOLD, DROP}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 32'd4.
- Single module; no sub-module is warranted.
- The counter pair, if enabled, stays inline under the macro.

Test Plan:
- Zero-wait memory, ack every cycle, stall=0 from RESET_PC=0: F_PC = 0,4,8,12 on consecutive cycles, F_valid=1 throughout.
- Ack with stall=1 for 3 cycles at PC 0x10:
  - HOLD presents 0x10 and the captured word unchanged.
  - imem_req=0 during HOLD.
  - After stall drops, next request is to 0x14.
- 2-wait memory, redirect to 0x200 in the first wait cycle:
  - imem_addr stays at old PC until ack.
  - That data is dropped (F_valid=0).
  - Next imem_addr = 0x200.
- Redirect to 0x103 in HOLD with stall=1: buffer discarded, next imem_addr=0x100, F_valid=0 that cycle.
- pc_q=0xFFFF_FFFC, ack, no stall: next imem_addr=0x0000_0000.
- Assert rst=0 mid-wait with imem_req=1: imem_req=0 and F_instruction=NOP immediately (asynchronous); after release, fetch restarts at RESET_PC.
